// File: rtl/bcd_pkg.sv
// Shared definitions for the sequential binary-to-BCD converter.
// Holds the FSM state encoding, the digit value used to flag overflow,
// and a helper that sizes the shift-step counter.
package bcd_pkg;

    // Converter phases: waiting for input, shifting one bit per clock, holding the result
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Digit pattern driven on every BCD digit when the value does not fit
    localparam logic [3:0] BCD_ERR_DIGIT = 4'hF;

    // Number of bits needed to hold a down-counter that starts at n
    function automatic int cntWidth(input int n);
        if (n < 2) begin
            return 1;
        end
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// Single-digit double-dabble correction.
// A digit of five or more gets three added so that the following left shift
// carries correctly into the next decimal digit. Purely combinational.
module bcd_digit_adj (
    input  logic [3:0] d_in,
    output logic [3:0] d_out
);

    // Add three to any digit that would reach ten or more after doubling
    always_comb begin
        d_out = d_in;
        if (d_in >= 4'd5) begin
            d_out = d_in + 4'd3;
        end
    end

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter (shift-add-3, one input bit per clock).
// Accepts a value over a valid/ready handshake, runs BIN_W shift steps and
// presents the packed BCD result until the consumer takes it. A sticky flag
// records any significant bit pushed out of the top digit, in which case the
// result is replaced by all-F digits.
module bin2bcd_seq
    import bcd_pkg::*;
#(
    parameter int BIN_W  = 8,
    parameter int DIGITS = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [BIN_W-1:0]      in_bin,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  ovf
);

    localparam int BCD_W = 4 * DIGITS;
    localparam int CNT_W = cntWidth(BIN_W);

    localparam logic [CNT_W-1:0] CNT_START = CNT_W'(BIN_W);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(1);
    localparam logic [BCD_W-1:0] ERR_BCD   = {DIGITS{BCD_ERR_DIGIT}};

    state_t             r_state;
    logic [BIN_W-1:0]   r_binSr;
    logic [BCD_W-1:0]   r_bcdAcc;
    logic               r_ovfSticky;
    logic [CNT_W-1:0]   r_count;
    logic [BCD_W-1:0]   r_bcd;
    logic               r_ovf;
    logic               r_outValid;

    logic [BCD_W-1:0]   w_corrAcc;
    logic [BCD_W-1:0]   w_shiftAcc;
    logic               w_nextOvf;

    // One correction cell per decimal digit of the accumulator
    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
        bcd_digit_adj u_adj (
            .d_in  (r_bcdAcc[4*g +: 4]),
            .d_out (w_corrAcc[4*g +: 4])
        );
    end

    // The corrected accumulator takes the next binary bit in at the bottom;
    // whatever leaves the top digit is lost, so a set MSB there means overflow
    assign w_shiftAcc = {w_corrAcc[BCD_W-2:0], r_binSr[BIN_W-1]};
    assign w_nextOvf  = r_ovfSticky | w_corrAcc[BCD_W-1];

    // Ready depends only on state so there is no path from in_valid
    assign in_ready  = (r_state == IDLE);
    assign out_valid = r_outValid;
    assign bcd       = r_bcd;
    assign ovf       = r_ovf;

    // Converter FSM together with the datapath and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_binSr     <= '0;
            r_bcdAcc    <= '0;
            r_ovfSticky <= 1'b0;
            r_count     <= '0;
            r_bcd       <= '0;
            r_ovf       <= 1'b0;
            r_outValid  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_binSr     <= in_bin;
                        r_bcdAcc    <= '0;
                        r_ovfSticky <= 1'b0;
                        r_ovf       <= 1'b0;
                        r_count     <= CNT_START;
                        r_state     <= SHIFT;
                    end
                end
                SHIFT: begin
                    r_bcdAcc    <= w_shiftAcc;
                    r_binSr     <= {r_binSr[BIN_W-2:0], 1'b0};
                    r_ovfSticky <= w_nextOvf;
                    r_count     <= r_count - CNT_LAST;
                    if (r_count == CNT_LAST) begin
                        r_bcd      <= w_nextOvf ? ERR_BCD : w_shiftAcc;
                        r_ovf      <= w_nextOvf;
                        r_outValid <= 1'b1;
                        r_state    <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_outValid <= 1'b0;
                        r_state    <= IDLE;
                    end
                end
                default: begin
                    r_state    <= IDLE;
                    r_outValid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Bench for bin2bcd_seq: a three-digit and a two-digit instance share one clock.
// Expected results come from a decimal reference model and are queued when a
// value is offered, then popped when the converter presents its result.
module tb_bin2bcd_seq;

    logic clk = 1'b0;
    logic rst;

    logic        aInValid, aInReady, aOutValid, aOutReady, aOvf;
    logic [7:0]  aInBin;
    logic [11:0] aBcd;

    logic        bInValid, bInReady, bOutValid, bOutReady, bOvf;
    logic [7:0]  bInBin;
    logic [7:0]  bBcd;

    int checkCount = 0;
    int passCount  = 0;

    typedef struct {
        logic [11:0] bcd;
        logic        ovf;
    } exp_t;

    exp_t expQ[$];

    // Free-running clock, 10 time units per period
    always #5 clk = ~clk;

    bin2bcd_seq #(.BIN_W(8), .DIGITS(3)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (aInValid),
        .in_ready  (aInReady),
        .in_bin    (aInBin),
        .out_valid (aOutValid),
        .out_ready (aOutReady),
        .bcd       (aBcd),
        .ovf       (aOvf)
    );

    bin2bcd_seq #(.BIN_W(8), .DIGITS(2)) dut2 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (bInValid),
        .in_ready  (bInReady),
        .in_bin    (bInBin),
        .out_valid (bOutValid),
        .out_ready (bOutReady),
        .bcd       (bBcd),
        .ovf       (bOvf)
    );

    // A presented result must stay up and unchanged until it is accepted
    assert property (@(posedge clk) disable iff (rst) (aOutValid && !aOutReady) |=> aOutValid)
        else $error("[TB] FAIL assert_hold_valid_a");
    assert property (@(posedge clk) disable iff (rst) (aOutValid && !aOutReady) |=> $stable(aBcd) && $stable(aOvf))
        else $error("[TB] FAIL assert_hold_bcd_a");
    assert property (@(posedge clk) disable iff (rst) (bOutValid && !bOutReady) |=> bOutValid)
        else $error("[TB] FAIL assert_hold_valid_b");
    assert property (@(posedge clk) disable iff (rst) (bOutValid && !bOutReady) |=> $stable(bBcd) && $stable(bOvf))
        else $error("[TB] FAIL assert_hold_bcd_b");

    // Decimal reference: split by repeated division, all-F when it does not fit
    function automatic exp_t refModel(input int value, input int digits);
        exp_t e;
        int   limit;
        int   rest;
        limit = 1;
        for (int i = 0; i < digits; i++) limit = limit * 10;
        e.bcd = '0;
        e.ovf = 1'b0;
        rest  = value;
        if (value >= limit) begin
            e.ovf = 1'b1;
            for (int i = 0; i < digits; i++) e.bcd[4*i +: 4] = 4'hF;
        end else begin
            for (int i = 0; i < digits; i++) begin
                e.bcd[4*i +: 4] = 4'(rest % 10);
                rest = rest / 10;
            end
        end
        return e;
    endfunction

    // Offer one value to the selected instance and queue its expected result
    task automatic applyStimulus(input int which, input int value, output logic timedOut);
        int waitCycles;
        waitCycles = 0;
        while (((which == 0) ? aInReady : bInReady) !== 1'b1 && waitCycles < 40) begin
            @(posedge clk); #1;
            waitCycles++;
        end
        timedOut = (waitCycles >= 40);
        if (which == 0) begin
            aInValid = 1'b1;
            aInBin   = 8'(value);
        end else begin
            bInValid = 1'b1;
            bInBin   = 8'(value);
        end
        @(posedge clk); #1;
        aInValid = 1'b0;
        bInValid = 1'b0;
        expQ.push_back(refModel(value, (which == 0) ? 3 : 2));
    endtask

    // Wait for a result and report what the instance shows plus the edge count
    task automatic collectOutput(input int which, output logic [11:0] bcdObs,
                                 output logic ovfObs, output int cycles,
                                 output logic timedOut);
        cycles = 0;
        while (((which == 0) ? aOutValid : bOutValid) !== 1'b1 && cycles < 40) begin
            @(posedge clk); #1;
            cycles++;
        end
        timedOut = (((which == 0) ? aOutValid : bOutValid) !== 1'b1);
        bcdObs   = (which == 0) ? aBcd : {4'h0, bBcd};
        ovfObs   = (which == 0) ? aOvf : bOvf;
    endtask

    // Hand the result back with out_ready high for one edge
    task automatic consumeOutput();
        aOutReady = 1'b1;
        bOutReady = 1'b1;
        @(posedge clk); #1;
    endtask

    // Reset state of both instances
    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checkCount++;
        if (aOutValid !== 1'b0) $display("[TB] FAIL reset_out_valid: got %b, expected 0", aOutValid);
        else passCount++;
        checkCount++;
        if (aBcd !== 12'h000) $display("[TB] FAIL reset_bcd: got %h, expected 000", aBcd);
        else passCount++;
        checkCount++;
        if (aOvf !== 1'b0 || bOvf !== 1'b0) $display("[TB] FAIL reset_ovf: got %b/%b, expected 0/0", aOvf, bOvf);
        else passCount++;
        rst = 1'b0;
        @(posedge clk); #1;
        checkCount++;
        if (aInReady !== 1'b1 || bInReady !== 1'b1) $display("[TB] FAIL reset_in_ready: got %b/%b, expected 1/1", aInReady, bInReady);
        else passCount++;
    endtask

    // Zero converts to zero with exactly BIN_W edges of latency
    task automatic test_zero();
        logic [11:0] bcdObs; logic ovfObs; int cycles; logic to1, to2; exp_t e;
        applyStimulus(0, 0, to1);
        collectOutput(0, bcdObs, ovfObs, cycles, to2);
        e = expQ.pop_front();
        checkCount++;
        if (to1 || to2) $display("[TB] FAIL zero_timeout: got timeout %b/%b, expected none", to1, to2);
        else passCount++;
        checkCount++;
        if (bcdObs !== e.bcd || ovfObs !== e.ovf) $display("[TB] FAIL zero_result: got %h ovf %b, expected %h ovf %b", bcdObs, ovfObs, e.bcd, e.ovf);
        else passCount++;
        checkCount++;
        if (cycles !== 8) $display("[TB] FAIL zero_latency: got %0d edges, expected 8", cycles);
        else passCount++;
        consumeOutput();
        checkCount++;
        if (aOutValid !== 1'b0 || aInReady !== 1'b1) $display("[TB] FAIL zero_return_idle: got valid %b ready %b, expected 0 1", aOutValid, aInReady);
        else passCount++;
    endtask

    // Maximum input and the 9/10 digit carry boundary on three digits
    task automatic test_three_digit();
        int values[3] = '{255, 9, 10};
        logic [11:0] bcdObs; logic ovfObs; int cycles; logic to1, to2; exp_t e;
        foreach (values[i]) begin
            applyStimulus(0, values[i], to1);
            collectOutput(0, bcdObs, ovfObs, cycles, to2);
            e = expQ.pop_front();
            checkCount++;
            if (to1 || to2 || bcdObs !== e.bcd || ovfObs !== e.ovf)
                $display("[TB] FAIL three_digit_%0d: got %h ovf %b timeout %b, expected %h ovf %b", values[i], bcdObs, ovfObs, to1 | to2, e.bcd, e.ovf);
            else passCount++;
            consumeOutput();
        end
    endtask

    // Two-digit instance: largest fitting value and values that overflow
    task automatic test_two_digit();
        int values[3] = '{99, 100, 150};
        logic [11:0] bcdObs; logic ovfObs; int cycles; logic to1, to2; exp_t e;
        foreach (values[i]) begin
            applyStimulus(1, values[i], to1);
            collectOutput(1, bcdObs, ovfObs, cycles, to2);
            e = expQ.pop_front();
            checkCount++;
            if (to1 || to2 || bcdObs !== e.bcd || ovfObs !== e.ovf)
                $display("[TB] FAIL two_digit_%0d: got %h ovf %b timeout %b, expected %h ovf %b", values[i], bcdObs, ovfObs, to1 | to2, e.bcd, e.ovf);
            else passCount++;
            consumeOutput();
        end
    endtask

    // Result held steady while the consumer stalls, then released
    task automatic test_backpressure();
        logic [11:0] bcdObs; logic ovfObs; int cycles; logic to1, to2; exp_t e;
        aOutReady = 1'b0;
        applyStimulus(0, 200, to1);
        collectOutput(0, bcdObs, ovfObs, cycles, to2);
        e = expQ.pop_front();
        checkCount++;
        if (to1 || to2 || bcdObs !== e.bcd || ovfObs !== e.ovf)
            $display("[TB] FAIL stall_result: got %h ovf %b timeout %b, expected %h ovf %b", bcdObs, ovfObs, to1 | to2, e.bcd, e.ovf);
        else passCount++;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            checkCount++;
            if (aOutValid !== 1'b1 || aBcd !== e.bcd || aOvf !== e.ovf || aInReady !== 1'b0)
                $display("[TB] FAIL stall_hold_%0d: got valid %b bcd %h ovf %b ready %b, expected 1 %h %b 0", i, aOutValid, aBcd, aOvf, aInReady, e.bcd, e.ovf);
            else passCount++;
        end
        consumeOutput();
        checkCount++;
        if (aOutValid !== 1'b0 || aInReady !== 1'b1) $display("[TB] FAIL stall_release: got valid %b ready %b, expected 0 1", aOutValid, aInReady);
        else passCount++;
    endtask

    // in_valid held high with a changing value while busy must be ignored
    task automatic test_ignore_busy();
        logic to1; int cycles; exp_t e; int waitCycles;
        waitCycles = 0;
        while (aInReady !== 1'b1 && waitCycles < 40) begin
            @(posedge clk); #1;
            waitCycles++;
        end
        to1 = (waitCycles >= 40);
        aInValid = 1'b1;
        aInBin   = 8'd173;
        @(posedge clk); #1;
        expQ.push_back(refModel(173, 3));
        cycles = 0;
        while (aOutValid !== 1'b1 && cycles < 40) begin
            aInBin = 8'($urandom_range(0, 255));
            @(posedge clk); #1;
            cycles++;
        end
        aInValid = 1'b0;
        e = expQ.pop_front();
        checkCount++;
        if (to1 || aOutValid !== 1'b1 || aBcd !== e.bcd || aOvf !== e.ovf)
            $display("[TB] FAIL busy_ignore: got %h ovf %b valid %b, expected %h ovf %b", aBcd, aOvf, aOutValid, e.bcd, e.ovf);
        else passCount++;
        checkCount++;
        if (cycles !== 8) $display("[TB] FAIL busy_latency: got %0d edges, expected 8", cycles);
        else passCount++;
        consumeOutput();
    endtask

    // Reset in the fourth shift cycle aborts, then a fresh conversion works
    task automatic test_reset_mid();
        logic [11:0] bcdObs; logic ovfObs; int cycles; logic to1, to2; exp_t e;
        applyStimulus(0, 99, to1);
        void'(expQ.pop_back());
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checkCount++;
        if (aOutValid !== 1'b0 || aBcd !== 12'h000 || aOvf !== 1'b0 || aInReady !== 1'b1)
            $display("[TB] FAIL midreset_state: got valid %b bcd %h ovf %b ready %b, expected 0 000 0 1", aOutValid, aBcd, aOvf, aInReady);
        else passCount++;
        applyStimulus(0, 42, to1);
        collectOutput(0, bcdObs, ovfObs, cycles, to2);
        e = expQ.pop_front();
        checkCount++;
        if (to1 || to2 || bcdObs !== e.bcd || ovfObs !== e.ovf || cycles !== 8)
            $display("[TB] FAIL midreset_next: got %h ovf %b after %0d edges, expected %h ovf %b after 8", bcdObs, ovfObs, cycles, e.bcd, e.ovf);
        else passCount++;
        consumeOutput();
    endtask

    // Every 8-bit value on the three-digit instance
    task automatic test_sweep();
        logic [11:0] bcdObs; logic ovfObs; int cycles; logic to1, to2; exp_t e;
        for (int v = 0; v < 256; v++) begin
            applyStimulus(0, v, to1);
            collectOutput(0, bcdObs, ovfObs, cycles, to2);
            e = expQ.pop_front();
            checkCount++;
            if (to1 || to2 || bcdObs !== e.bcd || ovfObs !== e.ovf)
                $display("[TB] FAIL sweep_%0d: got %h ovf %b timeout %b, expected %h ovf %b", v, bcdObs, ovfObs, to1 | to2, e.bcd, e.ovf);
            else passCount++;
            consumeOutput();
        end
    endtask

    // Overall time bound so a stuck handshake still ends the run
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $display("%0d/%0d checks passed", passCount, checkCount + 1);
        $fatal(1, "[TB] watchdog expired");
    end

    // Test sequence
    initial begin
        rst       = 1'b1;
        aInValid  = 1'b0;
        bInValid  = 1'b0;
        aInBin    = 8'h00;
        bInBin    = 8'h00;
        aOutReady = 1'b1;
        bOutReady = 1'b1;
        test_reset();
        test_zero();
        test_three_digit();
        test_two_digit();
        test_backpressure();
        test_ignore_busy();
        test_reset_mid();
        test_sweep();
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
